mpsub_seq: RTL and testbench
============================

Name: mpsub_seq

Overview:
Multi-precision subtract sequencer. It computes an NBYTES-wide A - B - bin by streaming one byte per cycle, LSB first, through a single shared external 8-bit subtractor (diff = a - b - c, borrow out). It registers the borrow between cycles and assembles the result. It sits between the ALU op decoder and the 8-bit subtract datapath, allowing wide operands without widening the datapath.

Parameters:
NBYTES, 4, operand width in bytes (legal range 2..16)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a_in  input  8*NBYTES  minuend
b_in  input  8*NBYTES  subtrahend
bin  input  1  initial borrow-in
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when result valid
result  output  8*NBYTES  difference, held until next accepted start
borrow_out  output  1  final borrow, held with result
zero  output  1  result==0 flag (see Optional Feature)
dp_a  output  8  byte to datapath a
dp_b  output  8  byte to datapath b
dp_c  output  1  borrow to datapath c
dp_diff  input  8  datapath difference
dp_borrow  input  1  datapath borrow out

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, busy=0, done=0, result=0, borrow_out=0, zero=0, operand and borrow registers=0, dp_a=dp_b=0, dp_c=0.
- States: IDLE, RUN, DONE.
- IDLE: dp_* outputs driven 0. start=1 latches a_in, b_in into operand registers, brw<=bin, idx<=0, and moves to RUN. Operands may change after the accepting edge.
- RUN: dp_a, dp_b, dp_c are combinational from the operand bytes [idx] and brw. The datapath is treated as combinational within the same cycle. Each edge: result byte[idx]<=dp_diff, brw<=dp_borrow, idx<=idx+1. When idx==NBYTES-1, the edge also sets borrow_out<=dp_borrow and moves to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Latency: start accepted at edge 0 -> done high in cycle NBYTES+1 (NBYTES RUN cycles + 1 DONE cycle). Next start can be accepted in the cycle after DONE. Throughput is one operation per NBYTES+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued.
- result is updated byte-wise during RUN. Consumers read result only on done or later.
- idx counter width is clog2(NBYTES). idx never wraps within an operation and is reset to 0 on accept.
- Reset asserted mid-RUN aborts immediately. All outputs return to reset values, and no done pulse is issued.
- Arithmetic is unsigned modulo 2^(8*NBYTES). borrow_out=1 iff A < B + bin.

Optional Feature:
- Macro MPSUB_ZERO_FLAG_EN.
- Defined: a zero-accumulator register zacc is set to 1 on accept. In RUN, zacc<=zacc & (dp_diff==0). zero<=final value on the DONE transition, held with result, and reset to 0.
- Undefined: zero is tied to 0 and no zacc logic is built.

Test Plan:
- NBYTES=4, A=0x00000005, B=0x00000003, bin=0, start pulse -> done in cycle 5 after accept; result=0x00000002, borrow_out=0, busy high for cycles 1..5.
- A=0x00000000, B=0x00000001, bin=0 -> full borrow ripple; result=0xFFFFFFFF, borrow_out=1; dp_c=0,1,1,1 across the four RUN cycles.
- A=0x12345678, B=0x12345678, bin=1 -> result=0xFFFFFFFF, borrow_out=1. Same operands with bin=0 -> result=0, borrow_out=0, zero=1 (with macro) or zero=0 (without macro).
- start held high continuously with changing a_in -> only the IDLE-cycle values are used; a new accept occurs only after DONE; exactly one done pulse per NBYTES+2 cycles.
- A=0x80000000, B=0x00000001, rst_n pulsed low in the 2nd RUN cycle -> outputs return to 0 asynchronously with no done pulse. A subsequent start computes result=0x7FFFFFFF, borrow_out=0.

Source files
------------

// File: rtl/mpsub_seq.sv
// Multi-precision A - B - bin sequencer: streams one byte per cycle, LSB first, through an external 8-bit subtractor.
// Optional result==0 flag built when MPSUB_ZERO_FLAG_EN is defined; otherwise zero is tied low.
module mpsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  borrow_out,
    output logic                  zero,
    output logic [7:0]            dp_a,
    output logic [7:0]            dp_b,
    output logic                  dp_c,
    input  logic [7:0]            dp_diff,
    input  logic                  dp_borrow
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               brw_q, brw_d;
    logic               borrow_q, borrow_d;
    logic               last_byte;
    logic               accept;

    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));
    assign accept    = (state_q == S_IDLE) && start;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        dp_a     = 8'h00;
        dp_b     = 8'h00;
        dp_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    brw_d   = bin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The external subtractor is combinational, so its answer is captured on this same edge.
                dp_a = a_q[{idx_q, 3'b000} +: 8];
                dp_b = b_q[{idx_q, 3'b000} +: 8];
                dp_c = brw_q;
                result_d[{idx_q, 3'b000} +: 8] = dp_diff;
                brw_d = dp_borrow;
                if (last_byte) begin
                    borrow_d = dp_borrow;
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign borrow_out = borrow_q;

`ifdef MPSUB_ZERO_FLAG_EN
    logic zacc_q, zacc_d;
    logic zero_q, zero_d;

    always_comb begin
        zacc_d = zacc_q;
        zero_d = zero_q;
        if (accept) begin
            zacc_d = 1'b1;
        end else if (state_q == S_RUN) begin
            zacc_d = zacc_q & (dp_diff == 8'h00);
            if (last_byte) begin
                zero_d = zacc_q & (dp_diff == 8'h00);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zacc_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            zacc_q <= zacc_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_mpsub_seq.sv
// Directed bench for mpsub_seq: vector table plus held-start and mid-run reset sequences.
module tb_mpsub_seq;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
`ifdef MPSUB_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           bin = 1'b0;
    logic           busy, done, borrow_out, zero;
    logic [W-1:0]   result;
    logic [7:0]     dp_a, dp_b, dp_diff;
    logic           dp_c, dp_borrow;

    int checks   = 0;
    int failures = 0;

    mpsub_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .bin(bin),
        .busy(busy), .done(done), .result(result), .borrow_out(borrow_out), .zero(zero),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_diff(dp_diff), .dp_borrow(dp_borrow)
    );

    // External 8-bit subtractor: diff = a - b - c, borrow out from bit 8.
    always_comb begin
        {dp_borrow, dp_diff} = {1'b0, dp_a} - {1'b0, dp_b} - {8'h00, dp_c};
    end

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] res;
        logic         bo;
        logic         zf;
        logic [3:0]   dpc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input int k);
        logic [3:0] dpc;
        dpc = 4'b0000;
        @(negedge clk);
        chk($sformatf("v%0d idle dp_a", k), 64'(dp_a), 64'h0);
        a_in  = vecs[k].a;
        b_in  = vecs[k].b;
        bin   = vecs[k].bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = ~vecs[k].a;
        b_in  = ~vecs[k].b;
        bin   = ~vecs[k].bi;
        for (int c = 1; c <= NBYTES + 1; c++) begin
            @(negedge clk);
            if (c <= NBYTES) dpc[c-1] = dp_c;
            chk($sformatf("v%0d busy c%0d", k, c), 64'(busy), 64'h1);
            chk($sformatf("v%0d done c%0d", k, c), 64'(done), (c == NBYTES + 1) ? 64'h1 : 64'h0);
        end
        chk($sformatf("v%0d result", k), 64'(result), 64'(vecs[k].res));
        chk($sformatf("v%0d borrow_out", k), 64'(borrow_out), 64'(vecs[k].bo));
        chk($sformatf("v%0d zero", k), 64'(zero), 64'(ZF & vecs[k].zf));
        chk($sformatf("v%0d dp_c seq", k), 64'(dpc), 64'(vecs[k].dpc));
        @(negedge clk);
        chk($sformatf("v%0d busy after", k), 64'(busy), 64'h0);
        chk($sformatf("v%0d done after", k), 64'(done), 64'h0);
        chk($sformatf("v%0d result held", k), 64'(result), 64'(vecs[k].res));
    endtask

    initial begin
        int ndone;
        int first_done;
        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1111};
        vecs[3] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1, 4'b0000};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 4'b1110};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1111};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1111};
        vecs[7] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 4'b0010};
        vecs[8] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 4'b0001};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset done", 64'(done), 64'h0);
        chk("reset result", 64'(result), 64'h0);
        chk("reset borrow_out", 64'(borrow_out), 64'h0);
        chk("reset zero", 64'(zero), 64'h0);
        chk("reset dp", {47'h0, dp_a, dp_b, dp_c}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_op(k);

        // start held high with changing operands: only IDLE-cycle values are taken
        @(negedge clk);
        a_in = 32'h00000005; b_in = 32'h00000003; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        first_done = 0;
        for (int c = 1; c <= NBYTES * 2 + 3; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = c;
                    chk("held first result", 64'(result), 64'h2);
                end
            end
            if (c == NBYTES + 2) begin
                a_in = 32'h00000010; b_in = 32'h00000003;
            end else begin
                a_in = 32'hDEAD0000 + 32'(c); b_in = 32'h01234567 ^ 32'(c);
            end
        end
        start = 1'b0;
        chk("held first done cycle", 64'(first_done), 64'(NBYTES + 1));
        chk("held done count", 64'(ndone), 64'h2);
        chk("held second result", 64'(result), 64'h0000000D);
        chk("held second borrow", 64'(borrow_out), 64'h0);
        @(negedge clk);
        chk("held idle after", 64'(busy), 64'h0);

        // reset in the second RUN cycle aborts with no done
        @(negedge clk);
        a_in = 32'h80000000; b_in = 32'h00000001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort busy before", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'h0);
        chk("abort result", 64'(result), 64'h0);
        chk("abort borrow_out", 64'(borrow_out), 64'h0);
        chk("abort dp", {47'h0, dp_a, dp_b, dp_c}, 64'h0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'h0);
        run_op(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
